// File: rtl/bin_pkg.sv
// Shared definitions for the 2x2 pixel binner.
// Holds the default frame geometry and the component, sum, line-RAM word and
// address widths used by the binner top and its line RAM.
package bin_pkg;

    localparam int IN_W_DEF = 640;   // active pixels per input line
    localparam int IN_H_DEF = 480;   // active lines per input frame
    localparam int PIX_W    = 10;    // one colour component
    localparam int HS_W     = 11;    // horizontal pair sum, lossless
    localparam int SUM_W    = 12;    // 2x2 block sum, lossless
    localparam int RAM_W    = 33;    // {hsR, hsG, hsB}
    localparam int ADDR_W   = 9;     // line RAM address, also output column width
    localparam int OY_W     = 8;     // output row width

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } pix_t;

    typedef struct packed {
        logic [HS_W-1:0] r;
        logic [HS_W-1:0] g;
        logic [HS_W-1:0] b;
    } hs_t;

endpackage

// File: rtl/bin_line_ram.sv
// Line buffer for the 2x2 binner: holds one row of horizontal pair sums.
// Simple dual-port, synchronous read with one clock of latency. The read
// register only updates when a read is issued, so read data stays put across
// input gaps until it is consumed.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable
//   raddr_i  read address
//   rdata_o  read data, valid the clock after re_i
module bin_line_ram #(
    parameter int DEPTH = 320,
    parameter int W     = 33,
    parameter int AW    = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [0:DEPTH-1];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_binner_2x2.sv
// 2x2 pixel binner: averages each 2x2 block of the input frame into one output
// pixel, halving both dimensions. Even rows store horizontal pair sums in a
// line RAM; odd rows add their pair sum to the stored one and emit the rounded
// average one clock after the odd pixel of the pair.
// Ports:
//   iCCD_PIXCLK           pixel clock, rising edge
//   iRST                  asynchronous reset, active-high
//   iCCD_R/G/B            input components
//   iCCD_DVAL             input pixel valid (gaps allowed)
//   iCCD_LVAL             line valid, falling edge ends a line
//   iCCD_FVAL             frame valid, rising edge starts a frame
//   oCCD_R/G/B            averaged components
//   oCCD_DVAL             one-cycle output strobe
//   oX_Cont / oY_Cont     output column / row
module pixel_binner_2x2
    import bin_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int IN_H = IN_H_DEF
) (
    input  logic              iCCD_PIXCLK,
    input  logic              iRST,
    input  logic [PIX_W-1:0]  iCCD_R,
    input  logic [PIX_W-1:0]  iCCD_G,
    input  logic [PIX_W-1:0]  iCCD_B,
    input  logic              iCCD_DVAL,
    input  logic              iCCD_LVAL,
    input  logic              iCCD_FVAL,
    output logic [PIX_W-1:0]  oCCD_R,
    output logic [PIX_W-1:0]  oCCD_G,
    output logic [PIX_W-1:0]  oCCD_B,
    output logic              oCCD_DVAL,
    output logic [ADDR_W-1:0] oX_Cont,
    output logic [OY_W-1:0]   oY_Cont
);

    // One extra bit so the counters can sit at IN_W / IN_H once saturated.
    localparam int XW = ADDR_W + 1;
    localparam int YW = OY_W + 1;
    localparam logic [XW-1:0] X_LIM = XW'(IN_W);
    localparam logic [YW-1:0] Y_LIM = YW'(IN_H);

    // Block sum to rounded average; max (4092 + 2) >> 2 = 1023, no saturation.
    function automatic logic [PIX_W-1:0] avg4(input logic [SUM_W-1:0] total);
        logic [SUM_W-1:0] s;
        s = total + SUM_W'(2);
        return s[SUM_W-1:2];
    endfunction

    logic [XW-1:0]     xin_q, xin_d;
    logic [YW-1:0]     yin_q, yin_d;
    pix_t              held_q, held_d;
    logic              lval_q, fval_q;
    logic              fval_low_q, fval_low_d;
    logic              armed_q, armed_d;
    pix_t              out_q, out_d;
    logic              dval_q, dval_d;
    logic [ADDR_W-1:0] ox_q, ox_d;
    logic [OY_W-1:0]   oy_q, oy_d;

    pix_t              cur;
    hs_t               hs;
    hs_t               ram_rd;
    logic [SUM_W-1:0]  tot_r, tot_g, tot_b;
    logic              fval_rise, lval_fall, accept, pix_ok, fire;
    logic              ram_we, ram_re;
    logic [XW-1:0]     x_eff;
    logic [YW-1:0]     y_eff;

    // A rise only counts once FVAL has been seen low since reset, so a frame
    // already in progress when reset releases is never picked up midway.
    assign fval_rise = iCCD_FVAL & ~fval_q & fval_low_q;
    assign lval_fall = ~iCCD_LVAL & lval_q;
    assign accept    = iCCD_DVAL & iCCD_LVAL;

    // A frame start restarts both counters in the same cycle it is seen.
    assign x_eff = fval_rise ? '0 : xin_q;
    assign y_eff = fval_rise ? '0 : yin_q;

    assign pix_ok = accept && (x_eff < X_LIM) && (y_eff < Y_LIM)
                    && (armed_q || fval_rise);
    assign ram_we = pix_ok &  x_eff[0] & ~y_eff[0];
    assign ram_re = pix_ok & ~x_eff[0] &  y_eff[0];
    assign fire   = pix_ok &  x_eff[0] &  y_eff[0];

    assign cur  = '{r: iCCD_R, g: iCCD_G, b: iCCD_B};
    assign hs.r = {1'b0, held_q.r} + {1'b0, cur.r};
    assign hs.g = {1'b0, held_q.g} + {1'b0, cur.g};
    assign hs.b = {1'b0, held_q.b} + {1'b0, cur.b};

    assign tot_r = {1'b0, hs.r} + {1'b0, ram_rd.r};
    assign tot_g = {1'b0, hs.g} + {1'b0, ram_rd.g};
    assign tot_b = {1'b0, hs.b} + {1'b0, ram_rd.b};

    bin_line_ram #(
        .DEPTH (IN_W / 2),
        .W     (RAM_W),
        .AW    (ADDR_W)
    ) u_line_ram (
        .clk_i   (iCCD_PIXCLK),
        .we_i    (ram_we),
        .waddr_i (x_eff[XW-1:1]),
        .wdata_i (hs),
        .re_i    (ram_re),
        .raddr_i (x_eff[XW-1:1]),
        .rdata_o (ram_rd)
    );

    always_comb begin
        xin_d      = x_eff;
        yin_d      = y_eff;
        held_d     = held_q;
        armed_d    = armed_q | fval_rise;
        fval_low_d = fval_low_q | ~iCCD_FVAL;

        if (accept && (x_eff < X_LIM)) begin
            xin_d = x_eff + XW'(1);
        end
        if (lval_fall) begin
            xin_d = '0;
            if (!fval_rise && (y_eff < Y_LIM)) begin
                yin_d = y_eff + YW'(1);
            end
        end

        // Pair state is dropped at line end / frame start, then a fresh even
        // pixel of this same cycle may reload it.
        if (lval_fall || fval_rise) begin
            held_d = '0;
        end
        if (pix_ok && !x_eff[0]) begin
            held_d = cur;
        end
    end

    always_comb begin
        out_d  = out_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        dval_d = fire;
        if (fire) begin
            out_d = '{r: avg4(tot_r), g: avg4(tot_g), b: avg4(tot_b)};
            ox_d  = x_eff[XW-1:1];
            oy_d  = y_eff[YW-1:1];
        end
    end

    always_ff @(posedge iCCD_PIXCLK or posedge iRST) begin
        if (iRST) begin
            xin_q      <= '0;
            yin_q      <= '0;
            held_q     <= '0;
            lval_q     <= 1'b0;
            fval_q     <= 1'b0;
            fval_low_q <= 1'b0;
            armed_q    <= 1'b0;
            out_q      <= '0;
            dval_q     <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
        end else begin
            xin_q      <= xin_d;
            yin_q      <= yin_d;
            held_q     <= held_d;
            lval_q     <= iCCD_LVAL;
            fval_q     <= iCCD_FVAL;
            fval_low_q <= fval_low_d;
            armed_q    <= armed_d;
            out_q      <= out_d;
            dval_q     <= dval_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
        end
    end

    assign oCCD_R    = out_q.r;
    assign oCCD_G    = out_q.g;
    assign oCCD_B    = out_q.b;
    assign oCCD_DVAL = dval_q;
    assign oX_Cont   = ox_q;
    assign oY_Cont   = oy_q;

endmodule

// File: tb/tb_pixel_binner_2x2.sv
module tb_pixel_binner_2x2;

    localparam int TW = 32;
    localparam int TH = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] r_i = '0, g_i = '0, b_i = '0;
    logic       dval_i = 1'b0, lval_i = 1'b0, fval_i = 1'b0;
    logic [9:0] o_r, o_g, o_b;
    logic       o_dval;
    logic [8:0] o_x;
    logic [7:0] o_y;

    pixel_binner_2x2 #(.IN_W(TW), .IN_H(TH)) dut (
        .iCCD_PIXCLK (clk),
        .iRST        (rst),
        .iCCD_R      (r_i),
        .iCCD_G      (g_i),
        .iCCD_B      (b_i),
        .iCCD_DVAL   (dval_i),
        .iCCD_LVAL   (lval_i),
        .iCCD_FVAL   (fval_i),
        .oCCD_R      (o_r),
        .oCCD_G      (o_g),
        .oCCD_B      (o_b),
        .oCCD_DVAL   (o_dval),
        .oX_Cont     (o_x),
        .oY_Cont     (o_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] r, g, b;
        logic [8:0] ox;
        logic [7:0] oy;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         mode = 0;
    int         seed = 0;
    bit         armed_m = 1'b0;
    bit         first_seen = 1'b0;
    logic [9:0] first_r;
    logic [8:0] first_x;
    logic [7:0] first_y;
    logic [9:0] row_m [0:TW-1][0:2];

    always @(posedge clk) cyc++;

    // Reference pixel source: 0 pattern, 1 constant 100/200/300,
    // 2 all 1023, 3 block values 1..4 scaled per component.
    function automatic logic [9:0] pv(input int x, input int y, input int c);
        int v;
        case (mode)
            1:       v = 100 * (c + 1);
            2:       v = 1023;
            3:       v = ((x % 2) + 2 * (y % 2) + 1) * (c + 1);
            default: v = (seed * 37 + x * 13 + y * 101 + c * 211 + x * y * 7) % 1024;
        endcase
        return v[9:0];
    endfunction

    function automatic logic [9:0] exp_avg(input int x, input int y, input int c);
        int s;
        s = row_m[x-1][c] + row_m[x][c] + pv(x - 1, y, c) + pv(x, y, c);
        return 10'((s + 2) >> 2);
    endfunction

    always @(negedge clk) begin
        if (o_dval === 1'b1) begin
            exp_t e;
            strobes++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_r = o_r;
                first_x = o_x;
                first_y = o_y;
            end
            vectors++;
            assert (q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_strobe got oX=%0d oY=%0d expected no strobe", o_x, o_y);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                assert ({o_r, o_g, o_b} === {e.r, e.g, e.b}) else begin
                    miscompares++;
                    $error("FAIL pixel got %0d/%0d/%0d expected %0d/%0d/%0d", o_r, o_g, o_b, e.r, e.g, e.b);
                end
                vectors++;
                assert ({o_x, o_y} === {e.ox, e.oy}) else begin
                    miscompares++;
                    $error("FAIL coords got %0d,%0d expected %0d,%0d", o_x, o_y, e.ox, e.oy);
                end
                vectors++;
                assert (cyc === e.cyc) else begin
                    miscompares++;
                    $error("FAIL latency got cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        assert ({o_r, o_g, o_b, o_x, o_y, o_dval} === 48'h0) else begin
            miscompares++;
            $error("FAIL %s got %h expected 0", tag, {o_r, o_g, o_b, o_x, o_y, o_dval});
        end
    endtask

    task automatic check_count(input string tag, input int expected);
        vectors++;
        assert (strobes === expected) else begin
            miscompares++;
            $error("FAIL %s got %0d strobes expected %0d", tag, strobes, expected);
        end
    endtask

    task automatic send_line(input int y, input int npix, input int gap_x,
                             input int gap_len, input int rst_x);
        exp_t e;
        lval_i = 1'b1;
        dval_i = 1'b0;
        tick();
        for (int x = 0; x < npix; x++) begin
            if (x == rst_x) begin
                vectors++;
                assert (q.size() === 0) else begin
                    miscompares++;
                    $error("FAIL pre_reset_queue got %0d pending expected 0", q.size());
                end
                rst = 1'b1;
                #2;
                check_zero_outputs("reset_midline");
                rst = 1'b0;
                armed_m = 1'b0;
            end
            if (x == gap_x) begin
                dval_i = 1'b0;
                repeat (gap_len) tick();
            end
            r_i = pv(x, y, 0);
            g_i = pv(x, y, 1);
            b_i = pv(x, y, 2);
            dval_i = 1'b1;
            if (armed_m && x < TW && y < TH) begin
                if (y % 2 == 0) begin
                    for (int c = 0; c < 3; c++) row_m[x][c] = pv(x, y, c);
                end else if (x % 2 == 1) begin
                    e.r = exp_avg(x, y, 0);
                    e.g = exp_avg(x, y, 1);
                    e.b = exp_avg(x, y, 2);
                    e.ox = 9'(x / 2);
                    e.oy = 8'(y / 2);
                    e.cyc = cyc + 1;
                    q.push_back(e);
                end
            end
            tick();
        end
        dval_i = 1'b0;
        lval_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input int nlines, input int npix, input int gap_y,
                              input int gap_x, input int gap_len,
                              input int rst_y, input int rst_x);
        fval_i = 1'b0;
        repeat (3) tick();
        fval_i = 1'b1;
        armed_m = 1'b1;
        strobes = 0;
        first_seen = 1'b0;
        tick();
        for (int y = 0; y < nlines; y++) begin
            send_line(y, npix, (y == gap_y) ? gap_x : -1, gap_len,
                      (y == rst_y) ? rst_x : -1);
        end
        fval_i = 1'b0;
        repeat (3) tick();
        vectors++;
        assert (q.size() === 0) else begin
            miscompares++;
            $error("FAIL queue_drain got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        repeat (3) tick();
        check_zero_outputs("reset_state");
        rst = 1'b0;
        tick();

        mode = 1;
        send_frame(TH, TW, -1, -1, 0, -1, -1);
        check_count("const_frame_count", (TW / 2) * (TH / 2));

        mode = 3;
        send_frame(TH, TW, -1, -1, 0, -1, -1);
        check_count("block_frame_count", (TW / 2) * (TH / 2));
        vectors++;
        assert ({first_r, first_x, first_y} === {10'd3, 9'd0, 8'd0}) else begin
            miscompares++;
            $error("FAIL block_first got R=%0d x=%0d y=%0d expected R=3 x=0 y=0", first_r, first_x, first_y);
        end

        mode = 2;
        send_frame(TH, TW, -1, -1, 0, -1, -1);
        check_count("max_frame_count", (TW / 2) * (TH / 2));

        mode = 0;
        seed = 1;
        send_frame(TH, TW, 3, 5, 5, -1, -1);
        check_count("gap_frame_count", (TW / 2) * (TH / 2));

        seed = 2;
        send_frame(TH + 2, TW + 1, -1, -1, 0, -1, -1);
        check_count("oversize_frame_count", (TW / 2) * (TH / 2));

        seed = 3;
        send_frame(TH, TW - 3, -1, -1, 0, -1, -1);
        check_count("short_odd_line_count", ((TW - 3) / 2) * (TH / 2));

        seed = 4;
        send_frame(TH, TW, -1, -1, 0, 5, 9);
        check_count("reset_frame_count", 2 * (TW / 2) + 4);

        seed = 5;
        send_frame(TH, TW, -1, -1, 0, -1, -1);
        check_count("post_reset_frame_count", (TW / 2) * (TH / 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_binner_2x2.md
PIXEL_BINNER_2X2 -- requirements
Module: pixel_binner_2x2

Interface
REQ-001 Parameter IN_W, default 640, input active pixels per line (even).
REQ-002 Parameter IN_H, default 480, input active lines per frame (even).
REQ-003 Clock and reset are decided: one clock, with asynchronous, active-high reset.
REQ-004 iCCD_PIXCLK  in  1  pixel clock; all logic is on the rising edge.
REQ-005 iRST  in  1  asynchronous reset, active-high.
REQ-006 iCCD_R / iCCD_G / iCCD_B  in  10 each  input pixel components.
REQ-007 iCCD_DVAL  in  1  input pixel valid; gaps are allowed inside a line.
REQ-008 iCCD_LVAL  in  1  line valid; a falling edge ends a line.
REQ-009 iCCD_FVAL  in  1  frame valid; a rising edge starts a frame.
REQ-010 oCCD_R / oCCD_G / oCCD_B  out  10 each  2x2-averaged pixel.
REQ-011 oCCD_DVAL  out  1  one-cycle output pixel strobe.
REQ-012 oX_Cont  out  9  output column, 0..IN_W/2-1.
REQ-013 oY_Cont  out  8  output row, 0..IN_H/2-1.

Function
REQ-014 Column counter xin: counts accepted pixels (DVAL=1 while LVAL=1); clears on the LVAL falling edge.
REQ-015 Row counter yin: clears on the FVAL rising edge; increments on each LVAL falling edge; saturates at IN_H.
REQ-016 Pixels with xin>=IN_W or yin>=IN_H are ignored: no RAM write, no output.
REQ-017 Even xin: register the component values as the held pair half.
REQ-018 Odd xin: horizontal sum hs = held + current, 11 bits per component, no loss.
REQ-019 Even yin: write {hsR,hsG,hsB} (33 bits) to line RAM address xin>>1; no output is produced.
REQ-020 Odd yin: on the even-xin cycle, issue a RAM read at xin>>1; the read data is valid on the next clock.
REQ-021 Odd yin, odd xin: total = hs + RAM word (12 bits); output = (total + 2) >> 2, truncated to 10 bits; no saturation is needed (max 1023).
REQ-022 Output registers load on the edge after the odd-xin pixel is sampled. Latency is 1 clock, with oCCD_DVAL high for exactly that cycle.
REQ-023 oX_Cont = xin>>1 and oY_Cont = yin>>1, registered alongside the pixel.
REQ-024 A DVAL gap between the even and odd pixel of a pair holds the pair half and the pending RAM read data until the odd pixel arrives.
REQ-025 A line ending at odd xin count drops the lone last pixel; pair state clears on the LVAL fall.
REQ-026 A line shorter than IN_W outputs only its complete pairs. RAM entries not written this row keep stale data and are not flagged.
REQ-027 An FVAL rise mid-line forces xin=0 and yin=0 and discards the held pair half.
REQ-028 Simultaneous LVAL fall and DVAL=1: the pixel is accepted first, then the counters update.
REQ-029 Outside output strobes, oCCD_R/G/B/oX/oY hold their last values.

Reset
REQ-030 iRST=1 asynchronously clears xin, yin, the held pair, the edge-detect registers, all outputs (0) and oCCD_DVAL (0).
REQ-031 Line RAM contents are not reset.
REQ-032 After iRST deasserts, output begins only after an FVAL rising edge.
REQ-033 Reset asserted mid-line aborts the line with no partial output.

Structure
REQ-034 Shared package bin_pkg: IN_W/IN_H defaults, widths HS_W=11 and SUM_W=12, the RAM word width 33, and the address width 9.
REQ-035 One sub-module, bin_line_ram: simple dual-port, IN_W/2 x 33 bits, synchronous read with 1-clock latency, write-first not required.
REQ-036 The output stream feeds the column-mirror stage directly; there is no extra buffering.

Verification
REQ-037 Constant frame R=100, G=200, B=300, 640x480 -> 76800 strobes; every output is 100/200/300, oX 0..319, oY 0..239.
REQ-038 2x2 block inputs 1,2,3,4 (R) at x=0..1, y=0..1 -> output R=(10+2)>>2=3 at oX=0, oY=0, one clock after the pixel at x=1, y=1.
REQ-039 All inputs 1023 -> outputs 1023, with no wrap.
REQ-040 DVAL gap of 5 cycles between the pixels at x=4 and x=5 on an odd row -> a single correct strobe at oX=2; no duplicate strobe.
REQ-041 Line of 641 pixels -> 320 strobes; pixel 640 is ignored. Frame of 482 lines -> 240 output rows.
REQ-042 iRST pulsed at x=300, y=101 -> outputs 0 immediately; no strobes until the next FVAL rise; the next frame is correct.
